simple_single_cpu: RTL and testbench
====================================

Name: simple_single_cpu

Overview:
Single-cycle 32-bit MIPS-subset processor: fetch, decode, execute, memory access and writeback all complete in one clk_i cycle. It contains a program counter, word-addressed instruction memory, a 32x32 register file and a 128-byte data memory. It is the top-level of the lab CPU. Verification probes its internal state hierarchically.

Parameters:
IM_WORDS, 128, instruction memory depth in 32-bit words
DM_WORDS, 32, data memory depth in 32-bit words (128 bytes)
SP_INIT, 128, reset value of register 29 (stack pointer)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-high (asserted = 1 clears state; name kept from codebase)

Behaviour:
- Required instance/signal names for hierarchical probing:
  - PC.pc_out_o: 32-bit current PC.
  - IM.Instr_Mem[0:IM_WORDS-1]: 32-bit instruction array, loadable by $readmemb, never reset.
  - RF.Reg_File[0:31]: register file.
  - DM.memory[0:DM_WORDS-1]: data memory, 32-bit words.
- Reset (async): PC=0; all Reg_File entries 0 except r29=SP_INIT; all DM words 0.
- Fetch: instr = Instr_Mem[PC>>2] (combinational). PC+4 computed each cycle.
- State commit: PC, RF write and DM write all occur on the same rising edge. RF and DM reads are combinational. Writes to r0 are ignored.
- R-type (op 000000), write rd, by funct:
  - add 100000: rs+rt, wraparound. sub 100010: rs-rt. and 100100. or 100101.
  - slt 101010: signed rs<rt gives 1, else 0.
  - sllv 000100: rt<<rs. srlv 000110: rt>>rs, logical. Shift amount is the full 32-bit rs value; ≥32 yields 0.
  - sll 000000: rt<<shamt[10:6]. srl 000010: rt>>shamt, logical.
  - mul 011000: low 32 bits of rs*rt.
  - jr 001000: PC=rs, no register write.
- I-type immediate instructions:
  - addi 001000: rt=rs+sext(imm).
  - ori 001101: rt=rs|zext(imm).
  - lui 001111: rt={16'h0000, imm}. This is team-defined behaviour: imm is zero-extended into the low half, not shifted.
- Memory instructions:
  - lw 100011: addr=rs+sext(imm); rt=DM word at addr[6:2].
  - sw 101011: DM word at addr[6:2] = rt.
  - Word-aligned only; byte order little-endian within a word. Bits above the DM range are ignored.
- Branches, target = PC+4+(sext(imm)<<2), otherwise PC+4:
  - beq 000100: taken if rs==rt.
  - bgt 000111: taken if rs>rt, unsigned compare.
  - bnez 000101: taken if rs!=0.
  - bgez 000001: taken if rs>=0, signed.
- Jumps:
  - j 000010: PC={PC+4[31:28], target26, 2'b00}.
  - jal 000011: r31=PC+4 and PC set to the same jump target.
- Undefined opcode/funct: no state change except PC=PC+4.
- Reset asserted mid-operation: immediate clear regardless of clock; IM contents preserved.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode and funct constants;
  - ALU-operation enum (ADD, SUB, AND, OR, SLT, SLL, SRL, MUL);
  - control-signal struct (reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch type, jump type, link);
  - SP_INIT.
- One natural sub-module: alu (32-bit, op enum in, result out), instantiated beside the named PC/IM/RF/DM instances and the decoder.

Test Plan:
- Reset, then release: PC=0, r29=128, all other registers and DM 0; after "addi r1,r0,5" then "addi r2,r0,-3", r1=5 and r2=0xFFFFFFFD, PC=8.
- ALU path: with r1=5, r2=-3:
  - add r3 gives 2; sub r4 gives 8; slt r5,r2,r1 gives 1; and/or give 0x5&0xFFFFFFFD=5 and 0xFFFFFFFD.
  - sll r6,r1,4 gives 80; srlv r7,r1,r1 with rs=5 gives 0; mul r8,r1,r1 gives 25.
- Memory: r29=128; "sw r1,-4(r29)" leaves DM.memory[31]=5; "lw r9,-4(r29)" gives r9=5; no other DM word changes.
- Branches at PC=0x20 with imm=2:
  - beq equal: next PC=0x2C; beq unequal: 0x24.
  - bnez r0: not taken. bgt with 7>3: taken.
  - bgez r2=-3: not taken; bgez r1: taken.
- Jumps: at PC=0x10, "jal 0x10" gives r31=0x14 and PC=0x40; "jr r31" returns PC to 0x14; "j 0" gives PC=0.
- lui r10,0x1234 gives r10=0x00001234. Write to r0 leaves r0=0. Async reset pulse mid-program clears PC/RF/DM without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU operations and control-word layout for the single-cycle CPU
package cpu_pkg;
    localparam logic [31:0] SP_INIT = 32'd128;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BGEZ = 6'b000001;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNEZ = 6'b000101;
    localparam logic [5:0] OP_BGT  = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_MUL  = 6'b011000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_MUL} alu_op_e;
    typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BGT, BR_BNEZ, BR_BGEZ} br_e;
    typedef enum logic [1:0] {JMP_NONE, JMP_J, JMP_JR} jmp_e;

    // a_zero forces the ALU A operand to 0 (lui); shamt_src selects instr[10:6] as A (sll/srl)
    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_write;
        br_e     branch;
        jmp_e    jump;
        logic    link;
        logic    imm_zext;
        logic    shamt_src;
        logic    a_zero;
        alu_op_e alu_op;
    } ctrl_t;
endpackage

// File: rtl/simple_single_cpu_alu.sv
// simple_single_cpu_alu: 32-bit ALU; shifts move b by the full 32-bit amount in a
module simple_single_cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] y
);
    // result select; shift amounts of 32 or more naturally yield 0
    always_comb
        y = op == ALU_ADD ? a + b :
            op == ALU_SUB ? a - b :
            op == ALU_AND ? a & b :
            op == ALU_OR  ? a | b :
            op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} :
            op == ALU_SLL ? b << a :
            op == ALU_SRL ? b >> a :
                            a * b;
endmodule

// File: rtl/simple_single_cpu.sv
// simple_single_cpu: single-cycle 32-bit MIPS-subset processor with PC, IM, RF and DM scopes
module simple_single_cpu
    import cpu_pkg::*;
#(
    parameter int          IM_WORDS = 128,
    parameter int          DM_WORDS = 32,
    parameter logic [31:0] SP_INIT  = cpu_pkg::SP_INIT
) (
    input logic clk_i,
    input logic rst_n
);
    localparam int IW = $clog2(IM_WORDS);
    localparam int DW = $clog2(DM_WORDS);

    logic [31:0] instr, pc4, next_pc, rs_val, rt_val, imm_ext, alu_a, alu_b, alu_y, wdata, dm_rdata;
    logic [4:0]  waddr;
    logic        taken, we;
    ctrl_t       c;

    if (1) begin : PC
        logic [31:0] pc_out_o;
        // program counter: cleared by reset, otherwise follows the selected next PC
        always_ff @(posedge clk_i or posedge rst_n)
            if (rst_n) pc_out_o <= '0;
            else pc_out_o <= next_pc;
    end

    if (1) begin : IM
        logic [31:0] Instr_Mem [0:IM_WORDS-1];
    end

    if (1) begin : RF
        logic [31:0] Reg_File [0:31];
        // register file: reset presets r29 to the stack top; r0 is never written
        always_ff @(posedge clk_i or posedge rst_n)
            if (rst_n) for (int i = 0; i < 32; i++) Reg_File[i] <= (i == 29) ? SP_INIT : 32'd0;
            else if (we) Reg_File[waddr] <= wdata;
    end

    if (1) begin : DM
        logic [31:0] memory [0:DM_WORDS-1];
        // data memory: word store addressed by the in-range bits of the effective address
        always_ff @(posedge clk_i or posedge rst_n)
            if (rst_n) for (int i = 0; i < DM_WORDS; i++) memory[i] <= '0;
            else if (c.mem_write) memory[alu_y[DW+1:2]] <= rt_val;
    end

    assign instr    = IM.Instr_Mem[PC.pc_out_o[IW+1:2]];
    assign pc4      = PC.pc_out_o + 32'd4;
    assign rs_val   = RF.Reg_File[instr[25:21]];
    assign rt_val   = RF.Reg_File[instr[20:16]];
    assign imm_ext  = c.imm_zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign alu_a    = c.a_zero ? 32'd0 : c.shamt_src ? {27'd0, instr[10:6]} : rs_val;
    assign alu_b    = c.alu_src ? imm_ext : rt_val;
    assign dm_rdata = DM.memory[alu_y[DW+1:2]];
    assign waddr    = c.link ? 5'd31 : c.reg_dst ? instr[15:11] : instr[20:16];
    assign wdata    = c.link ? pc4 : c.mem_to_reg ? dm_rdata : alu_y;
    assign we       = c.reg_write && waddr != 5'd0;

    // decoder: anything unrecognised leaves the all-zero control word, i.e. just PC+4
    always_comb begin
        c = '0;
        case (instr[31:26])
            OP_R: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                case (instr[5:0])
                    F_ADD:   c.alu_op = ALU_ADD;
                    F_SUB:   c.alu_op = ALU_SUB;
                    F_AND:   c.alu_op = ALU_AND;
                    F_OR:    c.alu_op = ALU_OR;
                    F_SLT:   c.alu_op = ALU_SLT;
                    F_MUL:   c.alu_op = ALU_MUL;
                    F_SLLV:  c.alu_op = ALU_SLL;
                    F_SRLV:  c.alu_op = ALU_SRL;
                    F_SLL:   begin c.alu_op = ALU_SLL; c.shamt_src = 1'b1; end
                    F_SRL:   begin c.alu_op = ALU_SRL; c.shamt_src = 1'b1; end
                    F_JR:    begin c.reg_write = 1'b0; c.jump = JMP_JR; end
                    default: c.reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
            OP_ORI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.imm_zext = 1'b1; c.alu_op = ALU_OR; end
            OP_LUI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.imm_zext = 1'b1; c.a_zero = 1'b1; c.alu_op = ALU_OR; end
            OP_LW:   begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            OP_SW:   begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
            OP_BEQ:  c.branch = BR_BEQ;
            OP_BGT:  c.branch = BR_BGT;
            OP_BNEZ: c.branch = BR_BNEZ;
            OP_BGEZ: c.branch = BR_BGEZ;
            OP_J:    c.jump = JMP_J;
            OP_JAL:  begin c.jump = JMP_J; c.link = 1'b1; c.reg_write = 1'b1; end
            default: ;
        endcase
    end

    // branch condition and next-PC selection; bgt compares unsigned, bgez signed
    always_comb begin
        taken   = c.branch == BR_BEQ  ? rs_val == rt_val :
                  c.branch == BR_BGT  ? rs_val > rt_val :
                  c.branch == BR_BNEZ ? rs_val != 32'd0 :
                  c.branch == BR_BGEZ ? !rs_val[31] : 1'b0;
        next_pc = c.jump == JMP_JR ? rs_val :
                  c.jump == JMP_J  ? {pc4[31:28], instr[25:0], 2'b00} :
                  taken            ? pc4 + {imm_ext[29:0], 2'b00} : pc4;
    end

    simple_single_cpu_alu ALU (.a(alu_a), .b(alu_b), .op(c.alu_op), .y(alu_y));
endmodule

// File: tb/tb_simple_single_cpu.sv
// tb_simple_single_cpu: directed programs with hand-computed architectural state checks
module tb_simple_single_cpu;
    localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, LUI = 6'b001111, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BGT = 6'b000111, BNEZ = 6'b000101, BGEZ = 6'b000001, J = 6'b000010, JAL = 6'b000011;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010;
    localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SLL = 6'b000000, F_SRL = 6'b000010, F_MUL = 6'b011000, F_JR = 6'b001000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] prog [0:127];

    simple_single_cpu dut (.clk_i(clk), .rst_n(rst_n));

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
        return {6'b000000, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input int t);
        return {op, t[25:0]};
    endfunction

    task automatic clear_prog;
        for (int i = 0; i < 128; i++) prog[i] = 32'd0;
    endtask

    task automatic boot;
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) dut.IM.Instr_Mem[i] = prog[i];
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        clear_prog();
        prog[0] = enc_i(ADDI, 0, 1, 5);
        prog[1] = enc_i(ADDI, 0, 2, -3);
        for (int i = 0; i < 128; i++) dut.IM.Instr_Mem[i] = prog[i];
        #1 rst_n = 1'b1;
        #1;
        checks++; if (dut.PC.pc_out_o !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", dut.PC.pc_out_o, 32'd0); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.RF.Reg_File[i] !== ((i == 29) ? 32'd128 : 32'd0)) begin
                failures++; $display("FAIL reset_rf[%0d] got=%h exp=%h", i, dut.RF.Reg_File[i], (i == 29) ? 32'd128 : 32'd0);
            end
        end
        for (int i = 0; i < 32; i++) begin
            checks++; if (dut.DM.memory[i] !== 32'd0) begin failures++; $display("FAIL reset_dm[%0d] got=%h exp=%h", i, dut.DM.memory[i], 32'd0); end
        end
        @(negedge clk);
        rst_n = 1'b0;
        run(2);
        checks++; if (dut.RF.Reg_File[1] !== 32'd5) begin failures++; $display("FAIL addi_r1 got=%h exp=%h", dut.RF.Reg_File[1], 32'd5); end
        checks++; if (dut.RF.Reg_File[2] !== 32'hFFFFFFFD) begin failures++; $display("FAIL addi_r2 got=%h exp=%h", dut.RF.Reg_File[2], 32'hFFFFFFFD); end
        checks++; if (dut.PC.pc_out_o !== 32'd8) begin failures++; $display("FAIL addi_pc got=%h exp=%h", dut.PC.pc_out_o, 32'd8); end
    endtask

    task automatic test_alu;
        int regs [0:14];
        logic [31:0] exp_v [0:14];
        clear_prog();
        prog[0]  = enc_i(ADDI, 0, 1, 5);
        prog[1]  = enc_i(ADDI, 0, 2, -3);
        prog[2]  = enc_r(1, 2, 3, 0, F_ADD);
        prog[3]  = enc_r(1, 2, 4, 0, F_SUB);
        prog[4]  = enc_r(2, 1, 5, 0, F_SLT);
        prog[5]  = enc_r(1, 2, 11, 0, F_AND);
        prog[6]  = enc_r(1, 2, 12, 0, F_OR);
        prog[7]  = enc_r(0, 1, 6, 4, F_SLL);
        prog[8]  = enc_r(1, 1, 7, 0, F_SRLV);
        prog[9]  = enc_r(1, 1, 8, 0, F_MUL);
        prog[10] = enc_i(LUI, 1, 10, 16'h1234);
        prog[11] = enc_i(ADDI, 0, 0, 7);
        prog[12] = enc_r(0, 2, 13, 28, F_SRL);
        prog[13] = enc_r(2, 1, 14, 0, F_SLLV);
        prog[14] = enc_r(1, 2, 15, 0, F_SLT);
        prog[15] = enc_r(3, 1, 16, 0, F_SLLV);
        prog[16] = enc_i(ORI, 1, 17, 16'h8000);
        regs  = '{3, 4, 5, 11, 12, 6, 7, 8, 10, 0, 13, 14, 15, 16, 17};
        exp_v = '{32'd2, 32'd8, 32'd1, 32'd5, 32'hFFFFFFFD, 32'd80, 32'd0, 32'd25, 32'h00001234,
                  32'd0, 32'hF, 32'd0, 32'd0, 32'd20, 32'h00008005};
        boot();
        run(17);
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (dut.RF.Reg_File[regs[k]] !== exp_v[k]) begin
                failures++; $display("FAIL alu_r%0d got=%h exp=%h", regs[k], dut.RF.Reg_File[regs[k]], exp_v[k]);
            end
        end
        checks++; if (dut.PC.pc_out_o !== 32'd68) begin failures++; $display("FAIL alu_pc got=%h exp=%h", dut.PC.pc_out_o, 32'd68); end
    endtask

    task automatic test_memory;
        clear_prog();
        prog[0] = enc_i(ADDI, 0, 1, 5);
        prog[1] = enc_i(SW, 29, 1, -4);
        prog[2] = enc_i(LW, 29, 9, -4);
        prog[3] = enc_i(ADDI, 0, 20, 16'h84);
        prog[4] = enc_i(SW, 20, 20, 0);
        prog[5] = enc_i(LW, 0, 21, 4);
        boot();
        run(6);
        checks++; if (dut.DM.memory[31] !== 32'd5) begin failures++; $display("FAIL sw_dm31 got=%h exp=%h", dut.DM.memory[31], 32'd5); end
        checks++; if (dut.RF.Reg_File[9] !== 32'd5) begin failures++; $display("FAIL lw_r9 got=%h exp=%h", dut.RF.Reg_File[9], 32'd5); end
        checks++; if (dut.DM.memory[1] !== 32'h84) begin failures++; $display("FAIL sw_wrap_dm1 got=%h exp=%h", dut.DM.memory[1], 32'h84); end
        checks++; if (dut.RF.Reg_File[21] !== 32'h84) begin failures++; $display("FAIL lw_r21 got=%h exp=%h", dut.RF.Reg_File[21], 32'h84); end
        for (int i = 0; i < 32; i++) begin
            if (i != 1 && i != 31) begin
                checks++; if (dut.DM.memory[i] !== 32'd0) begin failures++; $display("FAIL dm_untouched[%0d] got=%h exp=%h", i, dut.DM.memory[i], 32'd0); end
            end
        end
    endtask

    task automatic test_branch;
        logic [31:0] ins [0:10];
        logic [31:0] exp_pc [0:10];
        ins = '{enc_i(BEQ, 1, 1, 2), enc_i(BEQ, 1, 2, 2), enc_i(BNEZ, 0, 0, 2), enc_i(BNEZ, 1, 0, 2),
                enc_i(BGT, 4, 3, 2), enc_i(BGT, 3, 4, 2), enc_i(BGT, 2, 1, 2), enc_i(BGEZ, 2, 0, 2),
                enc_i(BGEZ, 1, 0, 2), enc_i(BGEZ, 0, 0, 2), enc_i(BEQ, 0, 0, -8)};
        exp_pc = '{32'h2C, 32'h24, 32'h24, 32'h2C, 32'h2C, 32'h24, 32'h2C, 32'h24, 32'h2C, 32'h2C, 32'h04};
        for (int k = 0; k < 11; k++) begin
            clear_prog();
            prog[0] = enc_i(ADDI, 0, 1, 5);
            prog[1] = enc_i(ADDI, 0, 2, -3);
            prog[2] = enc_i(ADDI, 0, 3, 3);
            prog[3] = enc_i(ADDI, 0, 4, 7);
            prog[8] = ins[k];
            boot();
            run(9);
            checks++;
            if (dut.PC.pc_out_o !== exp_pc[k]) begin
                failures++; $display("FAIL branch_%0d got=%h exp=%h", k, dut.PC.pc_out_o, exp_pc[k]);
            end
        end
    endtask

    task automatic test_jump;
        clear_prog();
        prog[4]  = enc_j(JAL, 26'h10);
        prog[5]  = enc_j(J, 0);
        prog[16] = enc_r(31, 0, 0, 0, F_JR);
        boot();
        run(5);
        checks++; if (dut.PC.pc_out_o !== 32'h40) begin failures++; $display("FAIL jal_pc got=%h exp=%h", dut.PC.pc_out_o, 32'h40); end
        checks++; if (dut.RF.Reg_File[31] !== 32'h14) begin failures++; $display("FAIL jal_r31 got=%h exp=%h", dut.RF.Reg_File[31], 32'h14); end
        run(1);
        checks++; if (dut.PC.pc_out_o !== 32'h14) begin failures++; $display("FAIL jr_pc got=%h exp=%h", dut.PC.pc_out_o, 32'h14); end
        checks++; if (dut.RF.Reg_File[0] !== 32'd0) begin failures++; $display("FAIL jr_r0 got=%h exp=%h", dut.RF.Reg_File[0], 32'd0); end
        run(1);
        checks++; if (dut.PC.pc_out_o !== 32'h0) begin failures++; $display("FAIL j_pc got=%h exp=%h", dut.PC.pc_out_o, 32'h0); end
    endtask

    task automatic test_undefined;
        clear_prog();
        prog[0] = {6'b111111, 5'd29, 5'd1, 16'd9};
        prog[1] = enc_r(29, 29, 1, 0, 6'b111111);
        prog[2] = {6'b010000, 5'd29, 5'd29, 16'hFFFC};
        boot();
        run(3);
        checks++; if (dut.PC.pc_out_o !== 32'd12) begin failures++; $display("FAIL undef_pc got=%h exp=%h", dut.PC.pc_out_o, 32'd12); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.RF.Reg_File[i] !== ((i == 29) ? 32'd128 : 32'd0)) begin
                failures++; $display("FAIL undef_rf[%0d] got=%h exp=%h", i, dut.RF.Reg_File[i], (i == 29) ? 32'd128 : 32'd0);
            end
        end
        for (int i = 0; i < 32; i++) begin
            checks++; if (dut.DM.memory[i] !== 32'd0) begin failures++; $display("FAIL undef_dm[%0d] got=%h exp=%h", i, dut.DM.memory[i], 32'd0); end
        end
    endtask

    task automatic test_async_reset;
        clear_prog();
        prog[0] = enc_i(ADDI, 0, 1, 5);
        prog[1] = enc_i(SW, 29, 1, -4);
        prog[2] = enc_i(LW, 29, 9, -4);
        prog[3] = enc_i(ADDI, 29, 29, -8);
        boot();
        run(4);
        checks++; if (dut.DM.memory[31] !== 32'd5) begin failures++; $display("FAIL pre_rst_dm31 got=%h exp=%h", dut.DM.memory[31], 32'd5); end
        #2 rst_n = 1'b1;
        #1;
        checks++; if (dut.PC.pc_out_o !== 32'd0) begin failures++; $display("FAIL arst_pc got=%h exp=%h", dut.PC.pc_out_o, 32'd0); end
        checks++; if (dut.RF.Reg_File[1] !== 32'd0) begin failures++; $display("FAIL arst_r1 got=%h exp=%h", dut.RF.Reg_File[1], 32'd0); end
        checks++; if (dut.RF.Reg_File[9] !== 32'd0) begin failures++; $display("FAIL arst_r9 got=%h exp=%h", dut.RF.Reg_File[9], 32'd0); end
        checks++; if (dut.RF.Reg_File[29] !== 32'd128) begin failures++; $display("FAIL arst_r29 got=%h exp=%h", dut.RF.Reg_File[29], 32'd128); end
        checks++; if (dut.DM.memory[31] !== 32'd0) begin failures++; $display("FAIL arst_dm31 got=%h exp=%h", dut.DM.memory[31], 32'd0); end
        checks++; if (dut.IM.Instr_Mem[1] !== enc_i(SW, 29, 1, -4)) begin failures++; $display("FAIL arst_im1 got=%h exp=%h", dut.IM.Instr_Mem[1], enc_i(SW, 29, 1, -4)); end
        @(negedge clk);
        run(2);
        checks++; if (dut.PC.pc_out_o !== 32'd0) begin failures++; $display("FAIL rst_hold_pc got=%h exp=%h", dut.PC.pc_out_o, 32'd0); end
        rst_n = 1'b0;
        run(1);
        checks++; if (dut.PC.pc_out_o !== 32'd4) begin failures++; $display("FAIL restart_pc got=%h exp=%h", dut.PC.pc_out_o, 32'd4); end
        checks++; if (dut.RF.Reg_File[1] !== 32'd5) begin failures++; $display("FAIL restart_r1 got=%h exp=%h", dut.RF.Reg_File[1], 32'd5); end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_memory();
        test_branch();
        test_jump();
        test_undefined();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
